apb_rr_arbiter: RTL and testbench

- Shares one APB master port among N_MASTERS requesters, e.g. core load/store unit, debug module and DMA, ahead of the APB interconnect.
- Round-robin arbitration.
- Latches the winning request and sequences the APB SETUP/ACCESS phases.
- Returns read data and error status to the granted requester with a one-cycle done pulse.

---
 rtl/apb_rr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | apb_rr_arbiter: round-robin sharing of one APB master port by N_MASTERS.    |
// | Optional macro APB_ARB_TIMEOUT_EN adds an ACCESS-phase timeout abort.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module apb_rr_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                PCLK,
  input  logic                                PRESET,
  input  logic [N_MASTERS-1:0]                req_i,
  input  logic [N_MASTERS*APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_MASTERS-1:0]                req_write_i,
  input  logic [N_MASTERS*APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic [N_MASTERS-1:0]                done_o,
  output logic [APB_DATA_WIDTH-1:0]           rdata_o,
  output logic                                err_o,
  output logic                                PSEL,
  output logic                                PENABLE,
  output logic [APB_ADDR_WIDTH-1:0]           PADDR,
  output logic                                PWRITE,
  output logic [APB_DATA_WIDTH-1:0]           PWDATA,
  input  logic [APB_DATA_WIDTH-1:0]           PRDATA,
  input  logic                                PREADY,
  input  logic                                PSLVERR
);

  localparam int IDX_W = $clog2(N_MASTERS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]                r_state;
  logic [IDX_W-1:0]          r_ptr;
  logic [IDX_W-1:0]          r_gnt;
  logic                      r_psel;
  logic                      r_penable;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic                      r_pwrite;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic [N_MASTERS-1:0]      r_done;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;

  logic [2*N_MASTERS-1:0]    w_req2;
  logic [N_MASTERS-1:0]      w_rot;
  logic [IDX_W-1:0]          w_off;
  logic [IDX_W:0]            w_sum;
  logic [IDX_W-1:0]          w_win;
  logic                      w_found;
  logic [APB_ADDR_WIDTH-1:0] w_addr;
  logic                      w_write;
  logic [APB_DATA_WIDTH-1:0] w_wdata;
  logic [IDX_W-1:0]          w_ptr_next;
  logic                      w_timeout;

  // Rotate requests so bit 0 is the pointer's requester; lowest set bit wins.
  assign w_req2  = {req_i, req_i};
  assign w_rot   = N_MASTERS'(w_req2 >> r_ptr);
  assign w_found = |req_i;

  always_comb begin
    w_off = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win = (w_sum >= (IDX_W+1)'(N_MASTERS)) ?
                 IDX_W'(w_sum - (IDX_W+1)'(N_MASTERS)) : w_sum[IDX_W-1:0];

  always_comb begin
    w_addr  = '0;
    w_write = 1'b0;
    w_wdata = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (w_win == IDX_W'(k)) begin
        w_addr  = req_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        w_write = req_write_i[k];
        w_wdata = req_wdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
    end
  end

  assign w_ptr_next = (r_gnt == IDX_W'(N_MASTERS - 1)) ? '0 : r_gnt + IDX_W'(1);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] r_tmo;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_tmo <= '0;
    end else if (r_state == S_SETUP) begin
      r_tmo <= '0;
    end else if ((r_state == S_ACCESS) && !PREADY) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && !PREADY &&
                     (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_done  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The cycle showing done_o is a mandatory bus-idle gap.
          if (w_found && (r_done == '0)) begin
            r_gnt    <= w_win;
            r_paddr  <= w_addr;
            r_pwrite <= w_write;
            r_pwdata <= w_wdata;
            r_psel   <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY || w_timeout) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= S_IDLE;
            r_done    <= N_MASTERS'(1) << r_gnt;
            r_err     <= PREADY ? PSLVERR : 1'b1;
            r_rdata   <= (PREADY && !r_pwrite) ? PRDATA : '0;
            r_ptr     <= w_ptr_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign done_o  = r_done;
  assign rdata_o = r_rdata;
  assign err_o   = r_err;
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PADDR   = r_paddr;
  assign PWRITE  = r_pwrite;
  assign PWDATA  = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_apb_rr_arbiter: directed stimulus, transaction-level reference model.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_apb_rr_arbiter;
  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
`ifdef APB_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    wr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            psel;
  logic            pen;
  logic [AW-1:0]   paddr;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  apb_rr_arbiter #(
    .N_MASTERS(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(clk), .PRESET(rst), .req_i(req), .req_addr_i(addr), .req_write_i(wr),
    .req_wdata_i(wdata), .done_o(done), .rdata_o(rdata), .err_o(err),
    .PSEL(psel), .PENABLE(pen), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: one transfer in flight, described by its age in cycles
  // since the grant (1 = select without enable, >=2 = enable phase).
  bit            m_valid = 0;
  bit            m_busy  = 0;
  int            m_age   = 0;
  int            m_waits = 0;
  int            m_gnt   = 0;
  int            m_ptr   = 0;
  logic [AW-1:0] m_addr  = '0;
  logic          m_write = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic          e_psel  = 1'b0;
  logic          e_pen   = 1'b0;
  logic [N-1:0]  e_done  = '0;
  logic [DW-1:0] e_rdata = '0;
  logic          e_err   = 1'b0;

  initial forever begin
    logic [N-1:0] shown;
    bit           found;
    @(posedge clk);
    if (rst) begin
      m_valid = 1; m_busy = 0; m_ptr = 0;
      e_psel = 0; e_pen = 0; e_done = '0; e_rdata = '0; e_err = 0;
    end else begin
      shown = e_done;
      e_done = '0; e_rdata = '0; e_err = 0;
      if (!m_busy) begin
        found = 0;
        if (shown == '0) begin
          for (int i = 0; i < N; i++) begin
            if (!found && req[(m_ptr + i) % N]) begin
              found   = 1;
              m_gnt   = (m_ptr + i) % N;
            end
          end
        end
        if (found) begin
          m_addr  = addr[m_gnt*AW +: AW];
          m_write = wr[m_gnt];
          m_wdata = wdata[m_gnt*DW +: DW];
          m_busy  = 1; m_age = 1;
          e_psel  = 1; e_pen = 0;
        end
      end else if (m_age == 1) begin
        m_age = 2; m_waits = 0; e_pen = 1;
      end else if (pready || (TMO_ON && m_waits == TMO - 1)) begin
        e_done = '0;
        e_done[m_gnt] = 1'b1;
        if (pready) begin
          e_err   = pslverr;
          e_rdata = m_write ? '0 : prdata;
        end else begin
          e_err   = 1'b1;
          e_rdata = '0;
        end
        m_ptr  = (m_gnt + 1) % N;
        m_busy = 0; e_psel = 0; e_pen = 0;
      end else begin
        m_waits++; m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("psel", psel, e_psel);
      chk("penable", pen, e_pen);
      chk("done", done, e_done);
      if (e_psel) begin
        chk("paddr", paddr, m_addr);
        chk("pwrite", pwrite, m_write);
        chk("pwdata", pwdata, m_wdata);
      end
      if (e_done != '0) begin
        chk("rdata", rdata, e_rdata);
        chk("err", err, e_err);
      end
    end
  end

  bit hold_all = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (!hold_all) req = req & ~done;
  endtask

  task automatic set_m(input int k, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    addr[k*AW +: AW]  = a;
    wr[k]             = w;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic wait_any(input int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (done != '0) return;
    end
  endtask

  logic [3:0] ord;
  int         cnt;
  int         ndone;

  initial begin
    rst = 1; req = '0; addr = '0; wr = '0; wdata = '0;
    prdata = '0; pready = 0; pslverr = 0;
    repeat (3) step();
    chk("rst_psel", psel, 0);
    chk("rst_penable", pen, 0);
    chk("rst_done", done, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    rst = 0;
    step();

    // Single read from master 0, zero wait states
    set_m(0, 32'h0000_1004, 1'b0, 32'h0);
    pready = 1; prdata = 32'hDEAD_BEEF; req = 2'b01;
    step();
    chk("t1_c1_psel", psel, 1);
    chk("t1_c1_penable", pen, 0);
    chk("t1_c1_paddr", paddr, 32'h0000_1004);
    step();
    chk("t1_c2_psel", psel, 1);
    chk("t1_c2_penable", pen, 1);
    step();
    chk("t1_c3_done", done, 2'b01);
    chk("t1_c3_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_c3_err", err, 0);
    chk("t1_c3_psel", psel, 0);
    step();
    chk("t1_c4_done", done, 2'b00);

    // Write from master 1 with three wait states; payload changes after grant
    set_m(1, 32'h0000_2000, 1'b1, 32'h1234_5678);
    pready = 0; prdata = 32'hCAFE_0000; req = 2'b10;
    step();
    step();
    set_m(1, 32'hFFFF_0000, 1'b1, 32'h0);
    repeat (3) step();
    chk("t2_wait_paddr", paddr, 32'h0000_2000);
    chk("t2_wait_pwdata", pwdata, 32'h1234_5678);
    chk("t2_wait_penable", pen, 1);
    chk("t2_wait_done", done, 2'b00);
    pready = 1;
    step();
    chk("t2_done", done, 2'b10);
    chk("t2_rdata", rdata, 32'h0);
    step();

    // Contention: both request continuously
    set_m(0, 32'h10, 1'b0, 32'h0);
    set_m(1, 32'h20, 1'b1, 32'hABCD);
    prdata = 32'h5A5A; pready = 1; hold_all = 1; req = 2'b11;
    ord = '0;
    for (int t = 0; t < 4; t++) begin
      wait_any(20);
      chk("t3_done_seen", done != '0, 1);
      ord[t] = done[1];
      chk("t3_gap_psel", psel, 0);
    end
    chk("t3_order", ord, 4'b1010);
    hold_all = 0; req = '0;
    step(); step();

    // Slave error, then a clean transfer
    pslverr = 1; set_m(0, 32'h30, 1'b0, 32'h0); prdata = 32'h77; req = 2'b01;
    wait_any(20);
    chk("t4_err_done", done, 2'b01);
    chk("t4_err_flag", err, 1);
    pslverr = 0;
    step();
    set_m(1, 32'h34, 1'b0, 32'h0); req = 2'b10;
    wait_any(20);
    chk("t4_next_done", done, 2'b10);
    chk("t4_next_err", err, 0);
    step();

    // Reset during a wait state; pointer returns to 0
    req = 2'b01;
    wait_any(20);
    chk("t5_pre_done", done, 2'b01);
    step();
    pready = 0; req = 2'b10;
    repeat (3) step();
    chk("t5_in_access", pen, 1);
    rst = 1;
    step();
    chk("t5_rst_psel", psel, 0);
    chk("t5_rst_penable", pen, 0);
    chk("t5_rst_done", done, 0);
    rst = 0; pready = 1; req = 2'b11;
    wait_any(20);
    chk("t5_first_grant", done, 2'b01);
    wait_any(20);
    chk("t5_second_grant", done, 2'b10);
    step();

    // Slave never ready
    pready = 0; prdata = 32'h55; set_m(0, 32'h40, 1'b0, 32'h0); req = 2'b01;
    cnt = 0; ndone = 0;
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      step();
      if (pen) cnt++;
      if (done != '0) break;
    end
    chk("t6_access_cycles", cnt, TMO);
    chk("t6_done", done, 2'b01);
    chk("t6_err", err, 1);
    chk("t6_rdata", rdata, 0);
    chk("t6_psel", psel, 0);
`else
    for (int i = 0; i < 30; i++) begin
      step();
      if (done != '0) ndone++;
    end
    chk("t6_no_done", ndone, 0);
    chk("t6_still_enabled", pen, 1);
    pready = 1;
    wait_any(5);
    chk("t6_late_done", done, 2'b01);
    chk("t6_late_rdata", rdata, 32'h55);
    chk("t6_late_err", err, 0);
`endif
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
